pc_fetch: RTL

- PC register and instruction-fetch sequencer for the miniRV core; sits directly downstream of the next-PC logic.
- Holds the architectural PC, which feeds back to the next-PC logic, and issues one request per instruction to instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched word to decode with a valid flag.
- Loads the next-PC value when the core retires the current instruction.

---
 rtl/pc_fetch_if.sv | 26 ++
 rtl/pc_fetch.sv | 96 +++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch port between pc_fetch (master) and instruction memory (slave).
// req/gnt: a request is accepted when req && gnt; addr is held stable while req is high.
// rvalid: rdata is valid for exactly that cycle; one response per accepted request.
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch.sv
// PC register and one-request-per-instruction fetch sequencer for the miniRV core.
// Optional misaligned-target trap enabled by defining PC_FETCH_MISALIGN_CHECK_EN.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     npc,
  input  logic            pc_we,
  output logic [31:0]     pc,
  pc_fetch_if.master      imem,
  output logic [31:0]     inst,
  output logic            inst_valid,
  output logic [31:0]     fetch_cnt,
  output logic            fetch_misalign,
  output logic [1:0]      state_dbg
);

`ifdef PC_FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_TRAP} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t state;

  assign state_dbg      = state;
  assign imem.imem_req  = (state == S_REQ) && !rst;
  assign imem.imem_addr = {pc[31:2], 2'b00};

`ifndef PC_FETCH_MISALIGN_CHECK_EN
  assign fetch_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      state      <= S_REQ;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
      fetch_cnt  <= 32'd0;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        S_REQ: begin
          // rvalid without gnt belongs to no request of ours and is dropped
          if (imem.imem_gnt && imem.imem_rvalid) begin
            inst       <= imem.imem_rdata;
            inst_valid <= 1'b1;
            fetch_cnt  <= fetch_cnt + 32'd1;
            state      <= S_HOLD;
          end else if (imem.imem_gnt) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            inst       <= imem.imem_rdata;
            inst_valid <= 1'b1;
            fetch_cnt  <= fetch_cnt + 32'd1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (pc_we) begin
            pc         <= npc;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
            if (npc[1:0] != 2'b00) begin
              fetch_misalign <= 1'b1;
              state          <= S_TRAP;
            end else begin
              state <= S_REQ;
            end
`else
            state <= S_REQ;
`endif
          end
        end
`ifdef PC_FETCH_MISALIGN_CHECK_EN
        S_TRAP: begin
          state <= S_TRAP;
        end
`endif
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule
